// File: rtl/unrot_seq_if.sv
// Valid/ready bundle for the sequential inverse rotator.
// The master modport is the upstream/downstream side and the slave modport is the rotator.
interface unrot_seq_if #(
  parameter int N      = 256,
  parameter int log2_N = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [0:N-1]      in_data;
  logic [0:log2_N-1] in_k;
  logic              out_valid;
  logic              out_ready;
  logic [0:N-1]      out_data;

  modport master (
    output in_valid, in_data, in_k, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_k, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/unrot_seq.sv
// Sequential inverse rotator: undoes a right-rotation by k with one butterfly stage per clock.
// Bit 0 is the MSB, so numerically the result is a rotate-left by k.
module unrot_seq #(
  parameter int N      = 256,
  parameter int log2_N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  unrot_seq_if.slave   bus,
  output logic         busy
);

  localparam int CNT_W = $clog2(log2_N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [0:N-1]      data_reg;
  logic [0:N-1]      out_data_reg;
  logic [0:log2_N-1] k_reg;
  logic [CNT_W-1:0]  stage_cnt;
  logic              out_valid_reg;
  logic [0:N-1]      stage_next;
  logic              last_stage;

  // Stage c moves every bit by N >> (c+1), but only when k bit c is set.
  always_comb begin
    stage_next = data_reg;
    for (int c = 0; c < log2_N; c++) begin
      if (stage_cnt == CNT_W'(c) && k_reg[c]) begin
        for (int j = 0; j < N; j++) begin
          stage_next[j] = data_reg[(j + (N >> (c + 1))) % N];
        end
      end
    end
  end

  assign last_stage = (stage_cnt == CNT_W'(log2_N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      data_reg      <= '0;
      out_data_reg  <= '0;
      k_reg         <= '0;
      stage_cnt     <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            data_reg  <= bus.in_data;
            k_reg     <= bus.in_k;
            stage_cnt <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          data_reg  <= stage_next;
          stage_cnt <= stage_cnt + CNT_W'(1);
          if (last_stage) begin
            out_data_reg  <= stage_next;
            out_valid_reg <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          // out_data is left as-is after hand-off so downstream can still observe it.
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign busy          = (state == BUSY);

endmodule

// File: tb/tb_unrot_seq.sv
// Directed bench for unrot_seq: an N=8 instance for hand-computed vectors and corner cases,
// and a default N=256 instance swept over every k behind a right-rotator model.
module tb_unrot_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy8, busy256;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  unrot_seq_if #(.N(8),   .log2_N(3)) bus8 ();
  unrot_seq_if #(.N(256), .log2_N(8)) bus256 ();

  unrot_seq #(.N(8), .log2_N(3)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8),
    .busy  (busy8)
  );

  unrot_seq #(.N(256), .log2_N(8)) dut256 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus256),
    .busy  (busy256)
  );

  typedef struct {
    logic [7:0] data;
    logic [2:0] k;
    logic [7:0] expected;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Presents one word to the N=8 instance and returns cycles from accept edge to out_valid.
  task automatic applyStimulus(input logic [7:0] data, input logic [2:0] k, output int latency);
    int guard;
    @(negedge clk);
    bus8.in_data  = data;
    bus8.in_k     = k;
    bus8.in_valid = 1'b1;
    guard = 0;
    while (!bus8.in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    latency = 0;
    while (!bus8.out_valid && latency < 20) begin
      @(posedge clk);
      #1;
      latency++;
    end
  endtask

  task automatic drain8();
    @(negedge clk);
    bus8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus8.out_ready = 1'b0;
    checkOutput("drain_out_valid", bus8.out_valid, 1'b0);
    checkOutput("drain_in_ready", bus8.in_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int guard;
    int prev_acc;
    logic [0:255] orig;
    logic [0:255] rr;

    vecs[0] = '{8'h80, 3'd1, 8'h01};
    vecs[1] = '{8'hB4, 3'd4, 8'h4B};
    vecs[2] = '{8'hB4, 3'd0, 8'hB4};
    vecs[3] = '{8'h96, 3'd7, 8'h4B};
    vecs[4] = '{8'h01, 3'd1, 8'h02};
    vecs[5] = '{8'h80, 3'd7, 8'h40};
    vecs[6] = '{8'hFF, 3'd5, 8'hFF};
    vecs[7] = '{8'h0F, 3'd3, 8'h78};
    vecs[8] = '{8'hC3, 3'd2, 8'h0F};
    vecs[9] = '{8'hA5, 3'd6, 8'h69};

    bus8.in_valid    = 1'b0;
    bus8.in_data     = '0;
    bus8.in_k        = '0;
    bus8.out_ready   = 1'b0;
    bus256.in_valid  = 1'b0;
    bus256.in_data   = '0;
    bus256.in_k      = '0;
    bus256.out_ready = 1'b1;

    // Inputs during reset must be ignored while in_ready stays high.
    #2;
    bus8.in_valid = 1'b1;
    bus8.in_data  = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", bus8.in_ready, 1'b1);
    checkOutput("rst_out_valid", bus8.out_valid, 1'b0);
    checkOutput("rst_out_data", bus8.out_data, 8'h00);
    checkOutput("rst_busy", busy8, 1'b0);
    bus8.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].data, vecs[i].k, lat);
      checkOutput("latency8", lat, 3);
      checkOutput("data8", bus8.out_data, vecs[i].expected);
      checkOutput("done_in_ready", bus8.in_ready, 1'b0);
      drain8();
    end

    // Stall in DONE with new in_valid pulses that must not disturb the held result.
    applyStimulus(8'h96, 3'd7, lat);
    checkOutput("stall_latency", lat, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus8.in_valid = i[0];
      bus8.in_data  = 8'hFF;
      bus8.in_k     = 3'd1;
      @(posedge clk);
      #1;
      checkOutput("stall_out_valid", bus8.out_valid, 1'b1);
      checkOutput("stall_out_data", bus8.out_data, 8'h4B);
      checkOutput("stall_in_ready", bus8.in_ready, 1'b0);
    end
    bus8.in_valid = 1'b0;
    drain8();

    // Asynchronous reset in the second BUSY cycle aborts the transfer.
    @(negedge clk);
    bus8.in_data  = 8'hB4;
    bus8.in_k     = 3'd4;
    bus8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("busy_flag", busy8, 1'b1);
    checkOutput("busy_in_ready", bus8.in_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", bus8.out_valid, 1'b0);
    checkOutput("abort_out_data", bus8.out_data, 8'h00);
    checkOutput("abort_busy", busy8, 1'b0);
    checkOutput("abort_in_ready", bus8.in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h0F, 3'd3, lat);
    checkOutput("post_rst_latency", lat, 3);
    checkOutput("post_rst_data", bus8.out_data, 8'h78);
    drain8();

    // out_ready already high when out_valid rises: hand-off on the following edge.
    @(negedge clk);
    bus8.in_data   = 8'hC3;
    bus8.in_k      = 3'd2;
    bus8.in_valid  = 1'b1;
    bus8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    lat = 0;
    while (!bus8.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("early_ready_latency", lat, 3);
    checkOutput("early_ready_data", bus8.out_data, 8'h0F);
    @(posedge clk);
    #1;
    checkOutput("early_ready_out_valid", bus8.out_valid, 1'b0);
    checkOutput("early_ready_in_ready", bus8.in_ready, 1'b1);
    checkOutput("early_ready_hold_data", bus8.out_data, 8'h0F);
    bus8.out_ready = 1'b0;

    // N=256: right-rotate random data by every k, then expect the original back.
    prev_acc = 0;
    for (int k = 0; k < 256; k++) begin
      for (int w = 0; w < 8; w++) orig[w*32 +: 32] = $urandom;
      for (int j = 0; j < 256; j++) rr[j] = orig[(j - k + 256) % 256];
      @(negedge clk);
      bus256.in_data  = rr;
      bus256.in_k     = 8'(k);
      bus256.in_valid = 1'b1;
      guard = 0;
      while (!bus256.in_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      @(posedge clk);
      #1;
      if (k > 0) checkOutput("interval256", cyc - prev_acc, 10);
      prev_acc = cyc;
      lat = 0;
      while (!bus256.out_valid && lat < 30) begin
        @(posedge clk);
        #1;
        lat++;
      end
      checkOutput("latency256", lat, 8);
      checkOutput("identity256", bus256.out_data, orig);
    end
    @(negedge clk);
    bus256.in_valid = 1'b0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/unrot_seq.md
Name: unrot_seq

Overview:
Sequential inverse rotator. Undoes a right-rotation by k: out[j] = in[(j + k) mod N], with bit 0 as the MSB of a [0:N-1] vector; numerically, this is a rotate-left by k.
Processes one butterfly stage per clock, so only one N-bit mux layer is needed instead of log2_N layers.
Sits on the receive side of the rotate path and restores the original bit order before downstream logic.
Uses a valid/ready handshake on both input and output.

Parameters:
N, 256, data width in bits; must equal 2^log2_N
log2_N, 8, number of stages; width of the rotate amount

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous reset, active low
in_valid  input  1  in_data/in_k are valid
in_ready  output  1  block can accept a transfer
in_data  input  [0:N-1]  rotated word; bit 0 is the MSB
in_k  input  [0:log2_N-1]  rotate amount; bit 0 is the MSB (weight N/2)
out_valid  output  1  out_data holds a completed result
out_ready  input  1  downstream accepts the result
out_data  output  [0:N-1]  un-rotated word
busy  output  1  high in BUSY state

Behaviour:
- Reset is asynchronous on the fall of rst_n:
  - state = IDLE, out_valid = 0, out_data = 0, busy = 0;
  - internal data register = 0, k register = 0, stage counter = 0.
- in_ready = 1 in IDLE, including while rst_n is low; inputs are ignored while rst_n is low.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - When in_valid is high at a clock edge: capture in_data into data_reg and in_k into k_reg, clear the stage counter, go to BUSY.
- BUSY:
  - in_ready = 0, busy = 1.
  - On each edge with stage counter c (0 to log2_N-1), let s = N >> (c+1).
  - If k_reg[c] = 1: data_reg[j] <= data_reg[(j + s) mod N] for all j. Otherwise data_reg is held.
  - c increments by 1.
  - After the edge that processes c = log2_N-1, go to DONE; out_data <= the final value, out_valid <= 1.
- DONE:
  - out_valid = 1, in_ready = 0.
  - out_data is stable until accepted.
  - When out_ready is high at an edge: out_valid <= 0, go to IDLE. out_data keeps its last value.
- Latency:
  - Accept at edge t gives out_valid high after edge t + log2_N.
  - Latency is fixed for every k, including k = 0.
  - Best-case throughput is one word per log2_N + 2 cycles.
- Index arithmetic is modulo N (wrap-around). Stage shifts are N/2, N/4, ..., 1, applied in k-bit order 0 to log2_N-1.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE; the upstream must hold it until in_ready is seen high.
- Reset asserted mid-BUSY or mid-DONE aborts the transaction with no output; the block returns to IDLE with cleared outputs.
- Composition with the right-rotator by the same k must be the identity for every data value and every k.

Test Plan:
- N=8, log2_N=3; in_data=8'h80, in_k=3'b001 (k=1) -> out_data=8'h01, out_valid rises exactly 3 cycles after accept.
- N=8; in_data=8'hB4, in_k=3'b100 (k=4) -> out_data=8'h4B; in_k=0 with the same data -> out_data=8'hB4, latency still 3.
- N=8; in_data=8'h96, in_k=7 -> out_data=8'h4B; hold out_ready=0 for 5 cycles -> out_data/out_valid stable, in_ready=0 throughout, in_valid pulses ignored.
- Default N=256: drive random data through the right-rotator then this block for all 256 k values, with back-to-back in_valid -> output equals the original data; one transfer per 10 cycles.
- Pulse rst_n low in the 2nd BUSY cycle -> out_valid=0 and out_data=0 immediately (asynchronous), in_ready=1 after release, next transfer correct.
- Apply out_ready high on the same edge out_valid rises -> transfer completes on the following edge; IDLE is entered and in_ready=1 one cycle later.
